// File: rtl/expression_evaluator_pkg.sv
// Shared definitions for the RPN expression evaluator and the fixed-point ALU:
// token kinds, ALU op codes and the sequencer state encoding.
package expression_evaluator_pkg;

    localparam logic [1:0] TOK_CONST = 2'd0;
    localparam logic [1:0] TOK_X     = 2'd1;
    localparam logic [1:0] TOK_OP    = 2'd2;
    localparam logic [1:0] TOK_END   = 2'd3;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_MUL = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT,
        ST_DRAIN,
        ST_FINISH
    } state_t;

    // Codes above MUL are reserved and make the evaluation fail.
    function automatic logic op_supported(input logic [2:0] code);
        return code <= ALU_MUL;
    endfunction

endpackage

// File: rtl/expression_evaluator_operand_stack.sv
// Operand stack: register array with push, pop-two/push-one replace, clear,
// and depth/full reporting. Exposes the top two entries combinationally.
module operand_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    localparam int DW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             replace,
    input  logic [WIDTH-1:0] replace_data,
    output logic [DW-1:0]    depth,
    output logic             full,
    output logic [WIDTH-1:0] top,
    output logic [WIDTH-1:0] second
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [DW-1:0] ONE = DW'(1);
    localparam logic [DW-1:0] TWO = DW'(2);
    localparam logic [DW-1:0] CAP = DW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DW-1:0]    top_idx;
    logic [DW-1:0]    second_idx;
    logic             do_push;

    assign full       = (depth == CAP);
    assign do_push    = push && !full;
    assign top_idx    = depth - ONE;
    assign second_idx = depth - TWO;

    // Empty slots read as zero so the ALU operand outputs are clean after reset.
    assign top    = (depth >= ONE) ? mem[top_idx[AW-1:0]]    : '0;
    assign second = (depth >= TWO) ? mem[second_idx[AW-1:0]] : '0;

    // Payload entries carry no reset; anything at or above depth is never read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[depth[AW-1:0]] <= push_data;
        end else if (replace) begin
            mem[second_idx[AW-1:0]] <= replace_data;
        end
    end

    // Stack pointer: push grows, replace consumes two and leaves one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth <= '0;
        end else if (clear) begin
            depth <= '0;
        end else if (do_push) begin
            depth <= depth + ONE;
        end else if (replace) begin
            depth <= depth - ONE;
        end
    end

endmodule

// File: rtl/expression_evaluator.sv
// Postfix token sequencer: pushes operands, hands each operator to the
// fixed-point ALU over its start/done handshake and returns f(x).
//
// state  | meaning
// IDLE   | done=1, waiting for start
// FETCH  | accepting tokens, pushing operands / checking operators
// ISSUE  | waiting for alu_done, then one alu_start pulse
// WAIT   | ALU busy; first cycle ignores alu_done, then write back
// DRAIN  | error seen, discarding tokens up to END
// FINISH | result_valid pulse
module expression_evaluator
    import expression_evaluator_pkg::*;
#(
    parameter int INTEGER_PART_WIDTH    = 8,
    parameter int FRACTIONAL_PART_WIDTH = 8,
    parameter int STACK_DEPTH           = 8,
    localparam int NW = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [NW-1:0] x,
    output logic          done,
    input  logic          token_valid,
    output logic          token_ready,
    input  logic [1:0]    token_kind,
    input  logic [NW-1:0] token_value,
    output logic          alu_start,
    input  logic          alu_done,
    output logic [2:0]    alu_op,
    output logic [NW-1:0] alu_a,
    output logic [NW-1:0] alu_b,
    input  logic [NW-1:0] alu_result,
    output logic          result_valid,
    output logic [NW-1:0] result,
    output logic          error
);
    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam logic [DW-1:0] DEPTH_ONE = DW'(1);
    localparam logic [DW-1:0] DEPTH_TWO = DW'(2);

    state_t        state_q;
    state_t        state_d;
    logic [NW-1:0] x_q;
    logic [2:0]    op_q;
    logic          wait_seen;

    logic          stk_clear;
    logic          stk_push;
    logic          stk_replace;
    logic [NW-1:0] stk_push_data;
    logic [DW-1:0] stk_depth;
    logic          stk_full;
    logic [NW-1:0] stk_top;
    logic [NW-1:0] stk_second;

    logic          tok_acc;
    logic [2:0]    op_code;
    logic          is_push_tok;

    assign tok_acc     = token_valid && token_ready;
    assign op_code     = token_value[2:0];
    assign is_push_tok = (token_kind == TOK_CONST) || (token_kind == TOK_X);

    operand_stack #(
        .WIDTH (NW),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (stk_clear),
        .push         (stk_push),
        .push_data    (stk_push_data),
        .replace      (stk_replace),
        .replace_data (alu_result),
        .depth        (stk_depth),
        .full         (stk_full),
        .top          (stk_top),
        .second       (stk_second)
    );

    // Operands come straight from the stack registers, so they hold still
    // for the whole ISSUE/WAIT window without extra latching.
    assign alu_op        = op_q;
    assign alu_a         = stk_second;
    assign alu_b         = stk_top;
    assign stk_push_data = (token_kind == TOK_X) ? x_q : token_value;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (tok_acc) begin
                    case (token_kind)
                        TOK_CONST, TOK_X: begin
                            if (stk_full) state_d = ST_DRAIN;
                        end
                        TOK_OP: begin
                            if (op_supported(op_code) && (stk_depth >= DEPTH_TWO)) begin
                                state_d = ST_ISSUE;
                            end else begin
                                state_d = ST_DRAIN;
                            end
                        end
                        default: state_d = ST_FINISH;
                    endcase
                end
            end
            ST_ISSUE: begin
                if (alu_done) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_seen && alu_done) state_d = ST_FETCH;
            end
            ST_DRAIN: begin
                if (tok_acc && (token_kind == TOK_END)) state_d = ST_FINISH;
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Per-state outputs and stack controls.
    always_comb begin
        done         = 1'b0;
        token_ready  = 1'b0;
        alu_start    = 1'b0;
        result_valid = 1'b0;
        stk_clear    = 1'b0;
        stk_push     = 1'b0;
        stk_replace  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                done      = 1'b1;
                stk_clear = start;
            end
            ST_FETCH: begin
                token_ready = 1'b1;
                stk_push    = token_valid && is_push_tok;
            end
            ST_ISSUE:  alu_start    = alu_done;
            ST_WAIT:   stk_replace  = wait_seen && alu_done;
            ST_DRAIN:  token_ready  = 1'b1;
            ST_FINISH: result_valid = 1'b1;
            default: ;
        endcase
    end

    // Captured abscissa, latched op code, WAIT-age flag, result and error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q       <= '0;
            op_q      <= ALU_ADD;
            wait_seen <= 1'b0;
            result    <= '0;
            error     <= 1'b0;
        end else begin
            // Low in the first WAIT cycle, where the ALU's done is still stale.
            wait_seen <= (state_q == ST_WAIT);
            if ((state_q == ST_IDLE) && start) begin
                x_q    <= x;
                result <= '0;
                error  <= 1'b0;
            end
            if ((state_q == ST_FETCH) && tok_acc) begin
                case (token_kind)
                    TOK_CONST, TOK_X: begin
                        if (stk_full) error <= 1'b1;
                    end
                    TOK_OP: begin
                        if (op_supported(op_code) && (stk_depth >= DEPTH_TWO)) begin
                            op_q <= op_code;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                    default: begin
                        if (stk_depth == DEPTH_ONE) begin
                            result <= stk_top;
                        end else begin
                            result <= '0;
                            error  <= 1'b1;
                        end
                    end
                endcase
            end
            if ((state_q == ST_DRAIN) && tok_acc && (token_kind == TOK_END)) begin
                result <= '0;
                error  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_expression_evaluator.sv
// Bench for expression_evaluator: directed vector table, random RPN streams
// against a queue-based reference evaluator, and a reset-during-MUL sequence.
module tb_expression_evaluator;

    localparam int DEPTH   = 4;
    localparam int ADD_LAT = 1;
    localparam int MUL_LAT = 16;

    localparam logic [1:0] K_CONST = 2'd0;
    localparam logic [1:0] K_X     = 2'd1;
    localparam logic [1:0] K_OP    = 2'd2;
    localparam logic [1:0] K_END   = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] value;
    } tok_t;

    typedef struct {
        logic [15:0] xv;
        int          first;
        int          ntok;
        logic [15:0] exp_res;
        logic        exp_err;
        int          exp_nalu;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        bit          timing;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] x;
    logic        done;
    logic        token_valid;
    logic        token_ready;
    logic [1:0]  token_kind;
    logic [15:0] token_value;
    logic        alu_start;
    logic        alu_done = 1'b1;
    logic [2:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_result = '0;
    logic        result_valid;
    logic [15:0] result;
    logic        error;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int          alu_cnt = 0;
    logic [15:0] alu_pend = '0;
    int          alu_starts = 0;
    int          proto_err = 0;
    int          hold_err = 0;
    bit          hold_armed = 0;
    logic [15:0] held_a = '0;
    logic [15:0] held_b = '0;
    logic [15:0] first_a = '0;
    logic [15:0] first_b = '0;

    vec_t vecs[$];
    tok_t pool[$];

    expression_evaluator #(
        .INTEGER_PART_WIDTH    (8),
        .FRACTIONAL_PART_WIDTH (8),
        .STACK_DEPTH           (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .x            (x),
        .done         (done),
        .token_valid  (token_valid),
        .token_ready  (token_ready),
        .token_kind   (token_kind),
        .token_value  (token_value),
        .alu_start    (alu_start),
        .alu_done     (alu_done),
        .alu_op       (alu_op),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_result   (alu_result),
        .result_valid (result_valid),
        .result       (result),
        .error        (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Q8.8 ALU behaviour: wrapping add/sub, signed multiply truncated to Q8.8.
    function automatic logic [15:0] alu_model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] p;
        sa = 32'($signed(a));
        sb = 32'($signed(b));
        p  = sa * sb;
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            default: return p[23:8];
        endcase
    endfunction

    // ALU model (no reset, like the real one) plus handshake/operand monitors.
    always @(posedge clk) begin
        if (!rst_n) hold_armed = 0;
        if (alu_start) begin
            alu_starts++;
            if (!alu_done || alu_cnt != 0) begin
                proto_err++;
            end else begin
                if (alu_starts == 1) begin
                    first_a = alu_a;
                    first_b = alu_b;
                end
                held_a     = alu_a;
                held_b     = alu_b;
                hold_armed = 1;
                alu_cnt    <= (alu_op == 3'd2) ? MUL_LAT : ADD_LAT;
                alu_pend   <= alu_model(alu_op, alu_a, alu_b);
                alu_done   <= 1'b0;
                alu_result <= 16'($urandom);
            end
        end else if (alu_cnt != 0) begin
            if (hold_armed && (alu_a !== held_a || alu_b !== held_b)) hold_err++;
            alu_cnt <= alu_cnt - 1;
            if (alu_cnt == 1) begin
                alu_done   <= 1'b1;
                alu_result <= alu_pend;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic tok_t tk(input logic [1:0] k, input logic [15:0] v);
        tok_t t;
        t.kind  = k;
        t.value = v;
        return t;
    endfunction

    task automatic add_vec(input logic [15:0] xv, input logic [15:0] r, input logic e, input int n,
                           input logic [15:0] a, input logic [15:0] b, input bit tm);
        vec_t v;
        v.xv = xv; v.first = pool.size(); v.ntok = 0;
        v.exp_res = r; v.exp_err = e; v.exp_nalu = n;
        v.exp_a = a; v.exp_b = b; v.timing = tm;
        vecs.push_back(v);
    endtask

    task automatic tok(input logic [1:0] k, input logic [15:0] val);
        pool.push_back(tk(k, val));
        vecs[vecs.size() - 1].ntok++;
    endtask

    // Reference evaluator: plain queue stack following the RPN rules.
    task automatic ref_eval(input logic [15:0] xv, input tok_t q[$],
                            output logic [15:0] res, output logic err, output int nalu);
        logic [15:0] stk[$];
        logic [15:0] a;
        logic [15:0] b;
        bit drain;
        bit fin;
        res = '0; err = 0; nalu = 0; drain = 0; fin = 0;
        for (int i = 0; i < q.size() && !fin; i++) begin
            if (drain) begin
                if (q[i].kind == K_END) begin
                    res = '0; err = 1; fin = 1;
                end
            end else if (q[i].kind == K_CONST || q[i].kind == K_X) begin
                if (stk.size() >= DEPTH) drain = 1;
                else stk.push_back(q[i].kind == K_X ? xv : q[i].value);
            end else if (q[i].kind == K_OP) begin
                if (q[i].value[2:0] > 3'd2 || stk.size() < 2) begin
                    drain = 1;
                end else begin
                    b = stk.pop_back();
                    a = stk.pop_back();
                    stk.push_back(alu_model(q[i].value[2:0], a, b));
                    nalu++;
                end
            end else begin
                if (stk.size() == 1) res = stk[0];
                else begin res = '0; err = 1; end
                fin = 1;
            end
        end
    endtask

    task automatic gen_expr(output tok_t q[$]);
        int d;
        int n;
        int r;
        q = {};
        d = 0;
        n = $urandom_range(1, 10);
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 99);
            if (r < 4) begin
                q.push_back(tk(K_OP, {13'($urandom), 3'($urandom_range(3, 7))}));
            end else if (d >= 2 && r < 55) begin
                q.push_back(tk(K_OP, {13'($urandom), 3'($urandom_range(0, 2))}));
                d--;
            end else if (r < 80) begin
                q.push_back(tk(K_X, 16'($urandom)));
                d++;
            end else begin
                q.push_back(tk(K_CONST, 16'($urandom)));
                d++;
            end
        end
        while (d > 1 && $urandom_range(0, 9) != 0) begin
            q.push_back(tk(K_OP, {13'($urandom), 3'($urandom_range(0, 2))}));
            d--;
        end
        q.push_back(tk(K_END, 16'($urandom)));
    endtask

    // One evaluation; noisy adds token bubbles and stray start/x activity.
    task automatic run_eval(input logic [15:0] xv, input tok_t toks[$], input bit noisy,
                            output logic [15:0] res, output logic err, output int nalu,
                            output int start_cyc, output int acc_cyc[$], output int rv_cyc);
        int guard;
        int idx;
        bit acc;
        guard = 0;
        while (!done && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        check("idle_before_start", done, 1);
        alu_starts = 0;
        proto_err  = 0;
        hold_err   = 0;
        x = xv;
        start = 1;
        @(posedge clk); #1;
        start_cyc = cyc;
        start = 0;
        idx = 0;
        guard = 0;
        acc_cyc = {};
        while (!result_valid && guard < 3000) begin
            if (noisy) begin
                start = 1'($urandom_range(0, 1));
                x = 16'($urandom);
            end
            if (idx < toks.size() && (!noisy || $urandom_range(0, 3) != 0)) begin
                token_valid = 1;
                token_kind  = toks[idx].kind;
                token_value = toks[idx].value;
            end else begin
                token_valid = 0;
                token_kind  = 2'($urandom);
                token_value = 16'($urandom);
            end
            acc = token_valid && token_ready;
            @(posedge clk); #1;
            if (acc) begin
                acc_cyc.push_back(cyc);
                idx++;
            end
            guard++;
        end
        start = 0;
        token_valid = 0;
        check("result_valid_seen", result_valid, 1);
        rv_cyc = cyc;
        res  = result;
        err  = error;
        nalu = alu_starts;
        check("alu_protocol", proto_err, 0);
        check("operand_hold", hold_err, 0);
        @(posedge clk); #1;
        check("result_valid_one_cycle", result_valid, 0);
        check("done_after_finish", done, 1);
        repeat (2) begin @(posedge clk); #1; end
        check("result_held", result, res);
        check("error_held", error, err);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached before the end of the test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tok_t        q[$];
        logic [15:0] res;
        logic        err;
        int          nalu;
        int          sc;
        int          rvc;
        int          accq[$];
        logic [15:0] m_res;
        logic        m_err;
        int          m_nalu;
        int          idx;
        int          guard;
        bit          acc;

        rst_n = 0; start = 0; x = '0;
        token_valid = 0; token_kind = '0; token_value = '0;
        #1;
        check("rst_done", done, 1);
        check("rst_token_ready", token_ready, 0);
        check("rst_alu_start", alu_start, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_result", result, 0);
        check("rst_error", error, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        // x, expected result, error, alu pulses, first operands, timing flag
        add_vec(16'h0200, 16'h0300, 0, 2, 16'h0200, 16'h0200, 0);
        tok(K_X, 0); tok(K_X, 0); tok(K_OP, 16'h0002); tok(K_CONST, 16'h0100); tok(K_OP, 16'hFFF9); tok(K_END, 0);
        add_vec(16'h0100, 16'h0180, 0, 1, 16'h0100, 16'h0080, 1);
        tok(K_X, 0); tok(K_CONST, 16'h0080); tok(K_OP, 16'h0000); tok(K_END, 0);
        add_vec(16'h0300, 16'h0000, 1, 0, 0, 0, 0);
        tok(K_CONST, 16'h0001); tok(K_OP, 16'h0000); tok(K_X, 0); tok(K_END, 0);
        add_vec(16'h0100, 16'h0000, 1, 0, 0, 0, 0);
        tok(K_X, 0); tok(K_X, 0); tok(K_X, 0); tok(K_X, 0); tok(K_X, 0); tok(K_END, 0);
        add_vec(16'h0100, 16'h0000, 1, 0, 0, 0, 0);
        tok(K_X, 0); tok(K_X, 0); tok(K_OP, 16'hA5F4); tok(K_END, 0);
        add_vec(16'h0100, 16'h0000, 1, 0, 0, 0, 0);
        tok(K_X, 0); tok(K_X, 0); tok(K_END, 0);
        add_vec(16'h0100, 16'h0000, 1, 0, 0, 0, 0);
        tok(K_END, 0);
        add_vec(16'h0300, 16'hFE00, 0, 1, 16'h0100, 16'h0300, 0);
        tok(K_CONST, 16'h0100); tok(K_X, 0); tok(K_OP, 16'h0001); tok(K_END, 0);
        add_vec(16'h0010, 16'h0040, 0, 3, 16'h0010, 16'h0010, 0);
        tok(K_X, 0); tok(K_X, 0); tok(K_X, 0); tok(K_X, 0);
        tok(K_OP, 0); tok(K_OP, 0); tok(K_OP, 0); tok(K_END, 0);

        foreach (vecs[i]) begin
            q = {};
            for (int j = 0; j < vecs[i].ntok; j++) q.push_back(pool[vecs[i].first + j]);
            run_eval(vecs[i].xv, q, 0, res, err, nalu, sc, accq, rvc);
            check($sformatf("v%0d_result", i), res, vecs[i].exp_res);
            check($sformatf("v%0d_error", i), err, vecs[i].exp_err);
            check($sformatf("v%0d_alu_starts", i), nalu, vecs[i].exp_nalu);
            check($sformatf("v%0d_tokens_taken", i), accq.size(), vecs[i].ntok);
            if (vecs[i].exp_nalu > 0) begin
                check($sformatf("v%0d_alu_a", i), first_a, vecs[i].exp_a);
                check($sformatf("v%0d_alu_b", i), first_b, vecs[i].exp_b);
            end
            if (vecs[i].timing) begin
                if (accq.size() == 4) begin
                    check("start_to_first_token", accq[0] - sc, 1);
                    check("push_back_to_back", accq[1] - accq[0], 1);
                    check("add_op_to_next_token", accq[3] - accq[2], 4);
                    check("end_to_result_valid", rvc - accq[3], 0);
                end else begin
                    check("timing_token_count", accq.size(), 4);
                end
            end
        end

        for (int n = 0; n < 60; n++) begin
            logic [15:0] xr;
            xr = 16'($urandom);
            gen_expr(q);
            ref_eval(xr, q, m_res, m_err, m_nalu);
            run_eval(xr, q, 1, res, err, nalu, sc, accq, rvc);
            check($sformatf("rnd%0d_result", n), res, m_res);
            check($sformatf("rnd%0d_error", n), err, m_err);
            check($sformatf("rnd%0d_alu_starts", n), nalu, m_nalu);
            check($sformatf("rnd%0d_tokens_taken", n), accq.size(), q.size());
        end

        // Reset while a MUL is in flight, then evaluate again.
        x = 16'h0300;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        q = {tk(K_X, 0), tk(K_X, 0), tk(K_OP, 16'h0002)};
        idx = 0;
        guard = 0;
        while (idx < 3 && guard < 100) begin
            token_valid = 1;
            token_kind  = q[idx].kind;
            token_value = q[idx].value;
            acc = token_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            guard++;
        end
        token_valid = 0;
        repeat (3) begin @(posedge clk); #1; end
        check("mul_in_flight", alu_done, 0);
        rst_n = 0;
        #1;
        check("midrst_done", done, 1);
        check("midrst_token_ready", token_ready, 0);
        check("midrst_alu_op", alu_op, 0);
        check("midrst_alu_a", alu_a, 0);
        check("midrst_alu_start", alu_start, 0);
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        q = {tk(K_X, 0), tk(K_CONST, 16'h0300), tk(K_OP, 16'h0000), tk(K_END, 0)};
        run_eval(16'h0100, q, 0, res, err, nalu, sc, accq, rvc);
        check("post_reset_result", res, 16'h0400);
        check("post_reset_error", err, 0);
        check("post_reset_alu_starts", nalu, 1);
        if (accq.size() == 4) check("issue_waited_for_alu", (accq[3] - accq[2]) > 4, 1);
        else check("post_reset_token_count", accq.size(), 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
